// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle load/store unit in front of a word SRAM.
// Decodes B/H/W accesses, stalls the core, flags misaligned/illegal ops.
// Ports: core side MemRead/MemWrite/Funct3/ALU_Result/WriteMemData in,
//   ReadMemData/Mem_Stall/Mem_Done/Mem_Fault out; SRAM side sram_* strobes,
//   word address, lane-replicated write data, sram_rdata back.
module data_mem_ctrl #(
  parameter int SRAM_AW    = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [2:0]         Funct3,
  input  logic [31:0]        ALU_Result,
  input  logic [31:0]        WriteMemData,
  output logic [31:0]        ReadMemData,
  output logic               Mem_Stall,
  output logic               Mem_Done,
  output logic               Mem_Fault,
  output logic               sram_en,
  output logic               sram_we,
  output logic [3:0]         sram_be,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  localparam int CW = 3;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         off_q, off_d;
  logic [2:0]         f3_q, f3_d;
  logic               ld_q, ld_d;
  logic [31:0]        rmd_q, rmd_d;
  logic               done_q, done_d;
  logic               flt_q, flt_d;
  logic               en_q, en_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic        req;
  logic        bad;
  logic [1:0]  size;
  logic [3:0]  st_be;
  logic [31:0] st_data;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val;

  // Bits above the SRAM word address alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ALU_Result[31:SRAM_AW+2];

  assign req  = MemRead | MemWrite;
  assign size = Funct3[1:0];

  // Stores have no unsigned variants; MemRead wins over MemWrite.
  assign bad = (Funct3 == 3'b011)
             | (Funct3[2:1] == 2'b11)
             | (!MemRead & Funct3[2])
             | ((size == 2'b01) & ALU_Result[0])
             | ((size == 2'b10) & (|ALU_Result[1:0]));

  always_comb begin
    st_be   = 4'b1111;
    st_data = WriteMemData;
    unique case (1'b1)
      size == 2'b00: begin
        st_be   = 4'b0001 << ALU_Result[1:0];
        st_data = {4{WriteMemData[7:0]}};
      end
      size == 2'b01: begin
        st_be   = ALU_Result[1] ? 4'b1100 : 4'b0011;
        st_data = {2{WriteMemData[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = WriteMemData;
      end
    endcase
  end

  always_comb begin
    lane_b = sram_rdata[{off_q, 3'b000} +: 8];
    lane_h = off_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    unique case (f3_q)
      3'b000:  ld_val = {{24{lane_b[7]}}, lane_b};
      3'b001:  ld_val = {{16{lane_h[15]}}, lane_h};
      3'b100:  ld_val = {24'd0, lane_b};
      3'b101:  ld_val = {16'd0, lane_h};
      default: ld_val = sram_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    f3_d    = f3_q;
    ld_d    = ld_q;
    rmd_d   = rmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    flt_d   = 1'b0;
    en_d    = 1'b0;
    we_d    = 1'b0;
    be_d    = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          off_d = ALU_Result[1:0];
          f3_d  = Funct3;
          ld_d  = MemRead;
          if (bad) begin
            state_d = DONE;
            done_d  = 1'b1;
            flt_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            en_d    = 1'b1;
            we_d    = !MemRead;
            be_d    = MemRead ? 4'b1111 : st_be;
            addr_d  = ALU_Result[SRAM_AW+1:2];
            if (!MemRead) wdata_d = st_data;
          end
        end
      end
      ISSUE: begin
        if (ld_q) begin
          state_d = WAIT;
          cnt_d   = CW'(RD_LATENCY - 1);
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          rmd_d   = ld_val;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      ld_q    <= 1'b0;
      rmd_q   <= '0;
      done_q  <= 1'b0;
      flt_q   <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      ld_q    <= ld_d;
      rmd_q   <= rmd_d;
      done_q  <= done_d;
      flt_q   <= flt_d;
      en_q    <= en_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign Mem_Stall = ((state_q == IDLE) & req)
                   | (state_q == ISSUE)
                   | (state_q == WAIT);

  assign ReadMemData = rmd_q;
  assign Mem_Done    = done_q;
  assign Mem_Fault   = flt_q;
  assign sram_en     = en_q;
  assign sram_we     = we_q;
  assign sram_be     = be_q;
  assign sram_addr   = addr_q;
  assign sram_wdata  = wdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed + random load/store checks for data_mem_ctrl
// against a byte-addressed memory model and a latency-L SRAM model.
module tb_data_mem_ctrl;

  localparam int AW    = 10;
  localparam int L     = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MEMB  = 4 * DEPTH;
  localparam int LIMIT = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemRead, MemWrite;
  logic [2:0]    Funct3;
  logic [31:0]   ALU_Result, WriteMemData;
  logic [31:0]   ReadMemData;
  logic          Mem_Stall, Mem_Done, Mem_Fault;
  logic          sram_en, sram_we;
  logic [3:0]    sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  data_mem_ctrl #(.SRAM_AW(AW), .RD_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .ALU_Result(ALU_Result),
    .WriteMemData(WriteMemData), .ReadMemData(ReadMemData),
    .Mem_Stall(Mem_Stall), .Mem_Done(Mem_Done), .Mem_Fault(Mem_Fault),
    .sram_en(sram_en), .sram_we(sram_we), .sram_be(sram_be),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  function automatic logic [31:0] seed(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // SRAM model: read data appears L cycles after the strobe, junk otherwise.
  logic        mem_init;
  logic [31:0] sram_mem [DEPTH];
  logic [31:0] pipe [L];
  assign sram_rdata = pipe[L-1];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < DEPTH; w++) sram_mem[w] <= seed(w);
    end else if (sram_en && sram_we) begin
      for (int i = 0; i < 4; i++)
        if (sram_be[i]) sram_mem[sram_addr][i*8 +: 8] <= sram_wdata[i*8 +: 8];
    end
    pipe[0] <= (sram_en && !sram_we) ? sram_mem[sram_addr] : $urandom;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  // Reference model: plain byte array plus the last successful load value.
  logic [7:0]  ref_mem [MEMB];
  logic [31:0] exp_rmd;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  int            last_lat;
  logic          last_we, last_flt;
  logic [3:0]    last_be;
  logic [31:0]   last_wd;
  logic [AW-1:0] last_ad;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_fault(input bit rd, input logic [2:0] f3,
                                   input logic [31:0] a);
    int n;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (!rd && f3[2]) return 1'b1;
    n = 1 << f3[1:0];
    return (a % 32'(n)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    int n;
    int base;
    logic [31:0] v;
    n = 1 << f3[1:0];
    base = int'(a % 32'(MEMB));
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 1);
    return v;
  endfunction

  // Called just after a rising edge with the DUT idle.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    int k, en_n, n, base;
    bit done, proto, ef;
    logic [31:0] rep;
    MemRead = rd; MemWrite = wr; Funct3 = f3;
    ALU_Result = a; WriteMemData = d;
    k = 0; en_n = 0; done = 0; proto = 1;
    last_we = 1'bx; last_be = 'x; last_wd = 'x; last_ad = 'x; last_flt = 1'bx;
    while (!done && k <= LIMIT) begin
      @(negedge clk);
      if (sram_en) begin
        en_n++;
        last_we = sram_we; last_be = sram_be;
        last_wd = sram_wdata; last_ad = sram_addr;
      end else if (sram_we || sram_be != 4'd0) proto = 0;
      if (Mem_Done) begin
        done = 1;
        last_flt = Mem_Fault;
        if (Mem_Stall) proto = 0;
      end else begin
        if (Mem_Fault || !Mem_Stall) proto = 0;
        k++;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
    last_lat = k;
    ef = ref_fault(rd, f3, a);
    n = 1 << f3[1:0];
    check("latency", 32'(k), ef ? 32'd1 : (rd ? 32'(2 + L) : 32'd2));
    check("fault", 32'(last_flt), 32'(ef));
    check("handshake", 32'(proto), 32'd1);
    check("en_count", 32'(en_n), ef ? 32'd0 : 32'd1);
    if (!ef) begin
      check("we", 32'(last_we), 32'(!rd));
      check("addr", 32'(last_ad), (a >> 2) % 32'(DEPTH));
      check("be", 32'(last_be),
            rd ? 32'hF : (((32'd1 << n) - 1) << (a % 4)));
      if (!rd) begin
        rep = (n == 1) ? {24'd0, d[7:0]} * 32'h01010101 :
              (n == 2) ? {16'd0, d[15:0]} * 32'h00010001 : d;
        check("wdata", last_wd, rep);
        base = int'(a % 32'(MEMB));
        for (int i = 0; i < n; i++) ref_mem[base+i] = 8'(d >> (8*i));
      end else begin
        exp_rmd = ref_load(f3, a);
      end
    end
    check("rmd", ReadMemData, exp_rmd);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rmd"}, ReadMemData, 32'd0);
    check({tag, "_ctl"},
          32'({Mem_Stall, Mem_Done, Mem_Fault, sram_en, sram_we, sram_be}),
          32'd0);
    check({tag, "_addr"}, 32'(sram_addr), 32'd0);
    check({tag, "_wdata"}, sram_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] s;
    int r;
    reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = 3'd0; ALU_Result = 32'd0; WriteMemData = 32'd0;
    mem_init = 1'b1;
    exp_rmd = 32'd0;
    for (int w = 0; w < DEPTH; w++) begin
      s = seed(w);
      for (int i = 0; i < 4; i++) ref_mem[4*w+i] = s[i*8 +: 8];
    end
    @(posedge clk); #1;
    mem_init = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    access(0, 1, 3'b010, 32'h00, 32'hDEADBEEF);
    check("sw_lat", 32'(last_lat), 32'd2);
    check("sw_be", 32'(last_be), 32'hF);
    access(1, 0, 3'b010, 32'h00, 32'h0);
    check("lw_lat", 32'(last_lat), 32'd4);
    check("lw_data", ReadMemData, 32'hDEADBEEF);

    access(0, 1, 3'b000, 32'h07, 32'h00000080);
    check("sb_be", 32'(last_be), 32'h8);
    check("sb_wdata", last_wd, 32'h80808080);
    access(1, 0, 3'b000, 32'h07, 32'h0);
    check("lb", ReadMemData, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h07, 32'h0);
    check("lbu", ReadMemData, 32'h00000080);

    access(0, 1, 3'b001, 32'h02, 32'h00008001);
    check("sh_be", 32'(last_be), 32'hC);
    check("sh_wdata", last_wd, 32'h80018001);
    access(1, 0, 3'b001, 32'h02, 32'h0);
    check("lh", ReadMemData, 32'hFFFF8001);
    access(1, 0, 3'b101, 32'h02, 32'h0);
    check("lhu", ReadMemData, 32'h00008001);

    access(1, 0, 3'b010, 32'h06, 32'h0);
    check("lw_mis_flt", 32'(last_flt), 32'd1);
    check("lw_mis_rmd", ReadMemData, 32'h00008001);
    access(0, 1, 3'b001, 32'h03, 32'h1234);
    check("sh_mis_flt", 32'(last_flt), 32'd1);
    check("sh_mis_lat", 32'(last_lat), 32'd1);

    access(0, 1, 3'b010, 32'h0C, 32'h12345678);
    access(1, 1, 3'b010, 32'h0C, 32'hFFFFFFFF);
    check("both_we", 32'(last_we), 32'd0);
    check("both_rmd", ReadMemData, 32'h12345678);
    access(1, 0, 3'b010, 32'h0C, 32'h0);
    check("both_mem", ReadMemData, 32'h12345678);
    access(1, 0, 3'b011, 32'h0C, 32'h0);
    check("f3_011_flt", 32'(last_flt), 32'd1);
    access(1, 0, 3'b010, 32'h8000_100C, 32'h0);
    check("alias", ReadMemData, 32'h12345678);

    MemRead = 1'b1; Funct3 = 3'b010; ALU_Result = 32'h00;
    repeat (3) @(negedge clk);
    check("mid_stall", 32'(Mem_Stall), 32'd1);
    reset = 1'b0; MemRead = 1'b0;
    #1;
    check_zero("midrst");
    exp_rmd = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 3'b010, 32'h10, 32'h0);
    check("post_rst_lw", ReadMemData, seed(4));

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 2);
      access(r != 1, r != 0, 3'($urandom_range(0, 7)),
             $urandom & 32'hFFFF_F03F, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Multi-cycle load/store unit between the ALU result/control signals of the single-cycle core and a synchronous, word-organised data SRAM with fixed read latency. It decodes byte/half/word accesses from funct3, generates byte enables and lane-aligned write data, and sign- or zero-extends load data. It stalls the core until each access completes, and flags misaligned accesses and illegal size encodings as faults.

Parameters:
SRAM_AW, 10, SRAM word-address width (depth = 2^SRAM_AW words of 32 bits)
RD_LATENCY, 2, cycles from sram_en to valid sram_rdata; legal range 1..4

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset
MemRead  input  1  load request, level, held by core while Mem_Stall=1
MemWrite  input  1  store request, level, held by core while Mem_Stall=1
Funct3  input  3  access size/sign from the instruction
ALU_Result  input  32  byte address
WriteMemData  input  32  store data from rs2, right-aligned
ReadMemData  output  32  extended load result
Mem_Stall  output  1  core must hold PC and inputs
Mem_Done  output  1  one-cycle completion pulse
Mem_Fault  output  1  one-cycle pulse, coincident with Mem_Done, on a faulted access
sram_en  output  1  SRAM access strobe
sram_we  output  1  SRAM write strobe, only with sram_en
sram_be  output  4  byte enables, bit i = byte lane i
sram_addr  output  SRAM_AW  word address = ALU_Result[SRAM_AW+1:2]
sram_wdata  output  32  lane-replicated store data
sram_rdata  input  32  SRAM read data

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including ReadMemData; any in-flight read is discarded.
- FSM states: IDLE, ISSUE, WAIT, DONE. Requests are sampled only in IDLE.
- IDLE with MemRead or MemWrite high: latch address, Funct3, write data, and op. MemRead wins if both are high; the store is dropped.
- Fault check in IDLE: go to DONE with fault flag set; no SRAM activity. Fault conditions:
  - Funct3 in {011, 110, 111}, or a store with Funct3[2]=1.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]!=00.
- No fault: go to ISSUE.
- ISSUE (1 cycle): registered outputs drive sram_en=1, sram_addr, and sram_be.
  - Store: sram_we=1, then DONE.
  - Load: sram_we=0, then WAIT.
- WAIT: counter runs RD_LATENCY cycles. sram_rdata is captured on the last WAIT edge, then DONE.
- DONE (1 cycle): Mem_Done=1, Mem_Fault per flag, Mem_Stall=0. Always returns to IDLE, ignoring inputs.
- Mem_Stall is combinational: 1 in IDLE when MemRead|MemWrite is high, and 1 in ISSUE and WAIT; 0 in DONE and in idle-without-request.
- Latency, request first seen in IDLE at cycle T:
  - Load: Done at T+2+RD_LATENCY.
  - Store: Done at T+2.
  - Fault: Done at T+1.
- Store lanes, o = addr[1:0]:
  - SB: be=1<<o; wdata = byte[7:0] replicated x4.
  - SH: be=0011 if o=00, 1100 if o=10; wdata = half[15:0] replicated x2.
  - SW: be=1111; wdata = data.
- Load extract (o = addr[1:0]):
  - LB/LBU: byte from lane o.
  - LH/LHU: half from lanes {o+1,o}.
  - LW: whole word.
  - Sign-extend for 000/001; zero-extend for 100/101.
  - sram_be=1111 for all loads.
- ReadMemData updates only on successful load completion (at DONE entry). It holds its value across stores, faults, and idle.
- sram_en/sram_we/sram_be are 0 in every state except ISSUE. sram_addr/sram_wdata hold their last values.
- Address bits above SRAM_AW+1 are ignored (aliasing wrap).
- Request withdrawn by the core mid-access: access still completes; the core violates protocol, and no recovery is required.

Test Plan:
- Reset mid-load (deassert reset during WAIT) -> all outputs 0 immediately; IDLE; after release, new LW to 0x10 completes normally.
- SW 0xDEADBEEF @0x00, then LW @0x00, RD_LATENCY=2 -> store Done at T+2 with be=1111; load Done at T+4 with ReadMemData=0xDEADBEEF; Mem_Stall high exactly T..T+3.
- SB 0x80 @0x07, then LB @0x07 and LBU @0x07 -> be=1000, wdata=0x80808080; LB=0xFFFFFF80, LBU=0x00000080.
- SH 0x8001 @0x02, then LH/LHU @0x02 -> be=1100, wdata=0x80018001; LH=0xFFFF8001, LHU=0x00008001.
- LW @0x06, and SH @0x03 -> Mem_Fault+Mem_Done at T+1; sram_en never 1; ReadMemData unchanged.
- MemRead=MemWrite=1 @0x0C, and Funct3=011 load -> first performs a read with sram_we=0 and memory unmodified; second faults.
